// File: rtl/bus_sequencer_if.sv
// Bus-timing bundle between the 16-phase sequencer and its consumers.
// The master side drives the timing, and the slave side raises SPI requests.
interface bus_sequencer_if;
  logic spi_valid_i;
  logic spi_ready_o;
  logic spi_en_o;
  logic cpu_en_o;
  logic cpu_clk_o;
  logic cpu_be_o;
  logic strobe_clk_o;
  logic setup_clk_o;

  modport master (
    input  spi_valid_i,
    output spi_ready_o,
    output spi_en_o,
    output cpu_en_o,
    output cpu_clk_o,
    output cpu_be_o,
    output strobe_clk_o,
    output setup_clk_o
  );

  modport slave (
    output spi_valid_i,
    input  spi_ready_o,
    input  spi_en_o,
    input  cpu_en_o,
    input  cpu_clk_o,
    input  cpu_be_o,
    input  strobe_clk_o,
    input  setup_clk_o
  );
endinterface

// File: rtl/bus_sequencer.sv
// 16-phase bus cycle generator: an SPI slot (phases 0-7) and a CPU slot (phases 8-15).
// Pending SPI requests are granted the SPI slot through a 4-phase valid/ready handshake.
module bus_sequencer #(
  parameter int SETUP_PHASE  = 1,
  parameter int STROBE_FIRST = 3,
  parameter int STROBE_LAST  = 5
) (
  input  logic            clk16_i,
  input  logic            reset_i,
  bus_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic spi_ready;
    logic spi_en;
    logic cpu_en;
    logic cpu_clk;
    logic cpu_be;
    logic strobe_clk;
    logic setup_clk;
  } bus_out_t;

  // Output values while reset is held; these also equal the phase-0 idle values.
  localparam bus_out_t OUT_RESET = '{
    spi_ready:  1'b0,
    spi_en:     1'b0,
    cpu_en:     1'b0,
    cpu_clk:    1'b0,
    cpu_be:     1'b1,
    strobe_clk: 1'b0,
    setup_clk:  1'b0
  };

  // Slot-relative timing points. Legal values satisfy
  // SETUP_PHASE < STROBE_FIRST <= STROBE_LAST <= 6.
  localparam logic [2:0] SETUP_SP      = 3'(SETUP_PHASE);
  localparam logic [2:0] STROBE_SP_LO  = 3'(STROBE_FIRST);
  localparam logic [2:0] STROBE_SP_HI  = 3'(STROBE_LAST);
  localparam logic [3:0] GRANT_PHASE   = 4'd15;
  localparam logic [3:0] LAST_SPI_PH   = 4'd7;

  logic [3:0] phase_q, phase_d;
  logic [2:0] sp_d;
  state_e     state_q, state_d;
  bus_out_t   out_q, out_d;

  // Next phase and handshake state.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    phase_d = phase_q + 4'd1;
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (phase_q == GRANT_PHASE && bus.spi_valid_i) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (phase_q == LAST_SPI_PH) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!bus.spi_valid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sp_d = phase_d[2:0];

  // Outputs are computed from the next phase/state so the registered value lines up with the phase it describes.
  always_comb begin
    out_d            = OUT_RESET;
    out_d.spi_en     = (state_d == ST_ACTIVE) && !phase_d[3];
    out_d.cpu_be     = !out_d.spi_en;
    out_d.spi_ready  = (state_d == ST_DONE);
    out_d.cpu_en     = phase_d[3];
    out_d.cpu_clk    = phase_d[3];
    out_d.strobe_clk = (sp_d >= STROBE_SP_LO) && (sp_d <= STROBE_SP_HI);
    out_d.setup_clk  = (sp_d == SETUP_SP);
  end

  always_ff @(posedge clk16_i) begin
    // NOTE: sequential state is updated with non-blocking assignments so all flops see pre-edge values.
    if (reset_i) begin
      phase_q <= 4'd0;
      state_q <= ST_IDLE;
      out_q   <= OUT_RESET;
    end else begin
      phase_q <= phase_d;
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign bus.spi_ready_o  = out_q.spi_ready;
  assign bus.spi_en_o     = out_q.spi_en;
  assign bus.cpu_en_o     = out_q.cpu_en;
  assign bus.cpu_clk_o    = out_q.cpu_clk;
  assign bus.cpu_be_o     = out_q.cpu_be;
  assign bus.strobe_clk_o = out_q.strobe_clk;
  assign bus.setup_clk_o  = out_q.setup_clk;

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: a cycle-indexed transaction model checked every cycle,
// directed scenarios with literal expectations, then randomized valid/reset traffic.
module tb_bus_sequencer;

  localparam int SETUP_PHASE  = 1;
  localparam int STROBE_FIRST = 3;
  localparam int STROBE_LAST  = 5;

  logic clk16_i = 1'b0;
  logic reset_i = 1'b1;

  bus_sequencer_if bus_if ();

  bus_sequencer #(
    .SETUP_PHASE (SETUP_PHASE),
    .STROBE_FIRST(STROBE_FIRST),
    .STROBE_LAST (STROBE_LAST)
  ) dut (
    .clk16_i(clk16_i),
    .reset_i(reset_i),
    .bus    (bus_if)
  );

  always #5 clk16_i = ~clk16_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_n(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: cycle index, phase of the current cycle, and the SPI window as a cycle interval.
  int cyc       = 0;
  int m_phase   = 0;
  int win_start = -100;
  bit m_busy    = 1'b0;
  bit m_ready   = 1'b0;
  bit model_ok  = 1'b0;

  always @(posedge clk16_i) begin
    cyc++;
    if (reset_i) begin
      m_phase  = 0;
      m_busy   = 1'b0;
      m_ready  = 1'b0;
      model_ok = 1'b1;
    end else begin
      if (m_ready && !bus_if.spi_valid_i) begin
        m_ready = 1'b0;
        m_busy  = 1'b0;
      end else if (!m_busy && m_phase == 15 && bus_if.spi_valid_i) begin
        m_busy    = 1'b1;
        win_start = cyc;
      end
      if (m_busy && cyc == win_start + 8) m_ready = 1'b1;
      m_phase = (m_phase + 1) % 16;
    end
  end

  // Compare every output against the model once per cycle, on the falling edge.
  always @(negedge clk16_i) begin : compare
    int  sp;
    bit  e_en;
    if (model_ok) begin
      sp   = m_phase % 8;
      e_en = m_busy && cyc >= win_start && cyc < win_start + 8;
      check("cpu_clk", bus_if.cpu_clk_o, m_phase >= 8);
      check("cpu_en", bus_if.cpu_en_o, m_phase >= 8);
      check("strobe", bus_if.strobe_clk_o, sp >= STROBE_FIRST && sp <= STROBE_LAST);
      check("setup", bus_if.setup_clk_o, sp == SETUP_PHASE);
      check("spi_en", bus_if.spi_en_o, e_en);
      check("cpu_be", bus_if.cpu_be_o, !e_en);
      check("spi_ready", bus_if.spi_ready_o, m_ready);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk16_i);
    #2;
  endtask

  task automatic goto_phase(input int p);
    for (int i = 0; i < 16 && m_phase != p; i++) step(1);
  endtask

  int first_en, first_rdy, en_cnt, rdy_cnt, hi_cnt, st_cnt, su_cnt, be_lo;

  initial begin
    bus_if.spi_valid_i = 1'b0;
    reset_i = 1'b1;
    step(3);

    // 1: idle timing over two bus cycles after reset release
    check("rst_spi_en", bus_if.spi_en_o, 1'b0);
    check("rst_cpu_be", bus_if.cpu_be_o, 1'b1);
    check("rst_cpu_clk", bus_if.cpu_clk_o, 1'b0);
    reset_i = 1'b0;
    hi_cnt = 0; st_cnt = 0; su_cnt = 0; en_cnt = 0; be_lo = 0;
    for (int i = 1; i <= 32; i++) begin
      step(1);
      if (i == 7)  check("p7_cpu_clk", bus_if.cpu_clk_o, 1'b0);
      if (i == 8)  check("p8_cpu_clk", bus_if.cpu_clk_o, 1'b1);
      if (i == 3)  check("p3_strobe", bus_if.strobe_clk_o, 1'b1);
      if (i == 6)  check("p6_strobe", bus_if.strobe_clk_o, 1'b0);
      if (i == 9)  check("p9_setup", bus_if.setup_clk_o, 1'b1);
      if (i == 10) check("p10_setup", bus_if.setup_clk_o, 1'b0);
      hi_cnt += int'(bus_if.cpu_clk_o);
      st_cnt += int'(bus_if.strobe_clk_o);
      su_cnt += int'(bus_if.setup_clk_o);
      en_cnt += int'(bus_if.spi_en_o);
      be_lo  += int'(!bus_if.cpu_be_o);
    end
    check_n("idle_cpu_clk_cnt", hi_cnt, 16);
    check_n("idle_strobe_cnt", st_cnt, 12);
    check_n("idle_setup_cnt", su_cnt, 4);
    check_n("idle_spi_en_cnt", en_cnt, 0);
    check_n("idle_cpu_be_low_cnt", be_lo, 0);

    // 2: valid at phase 14 -> window in next SPI slot, ready from phase 8
    goto_phase(14);
    bus_if.spi_valid_i = 1'b1;
    goto_phase(0);
    check("t2_spi_en_p0", bus_if.spi_en_o, 1'b1);
    check("t2_cpu_be_p0", bus_if.cpu_be_o, 1'b0);
    goto_phase(8);
    check("t2_ready_p8", bus_if.spi_ready_o, 1'b1);
    check("t2_cpu_be_p8", bus_if.cpu_be_o, 1'b1);
    goto_phase(10);
    bus_if.spi_valid_i = 1'b0;
    step(1);
    check("t2_ready_p11", bus_if.spi_ready_o, 1'b0);

    // 3+4: valid at phase 0 -> worst-case latency, then held 64 clks past ready
    goto_phase(0);
    bus_if.spi_valid_i = 1'b1;
    first_en = -1; first_rdy = -1; en_cnt = 0; rdy_cnt = 0;
    for (int i = 1; i <= 88; i++) begin
      step(1);
      if (bus_if.spi_en_o && first_en < 0) first_en = i;
      if (bus_if.spi_ready_o && first_rdy < 0) first_rdy = i;
      en_cnt  += int'(bus_if.spi_en_o);
      rdy_cnt += int'(bus_if.spi_ready_o);
    end
    check_n("t3_first_spi_en", first_en, 16);
    check_n("t3_first_ready", first_rdy, 24);
    check_n("t4_spi_en_cycles", en_cnt, 8);
    check_n("t4_ready_cycles", rdy_cnt, 65);
    bus_if.spi_valid_i = 1'b0;
    step(1);
    check("t4_ready_drop", bus_if.spi_ready_o, 1'b0);

    // 5: valid drops mid-window; slot completes, ready pulses once
    goto_phase(14);
    bus_if.spi_valid_i = 1'b1;
    goto_phase(3);
    check("t5_spi_en_p3", bus_if.spi_en_o, 1'b1);
    bus_if.spi_valid_i = 1'b0;
    goto_phase(7);
    check("t5_spi_en_p7", bus_if.spi_en_o, 1'b1);
    step(1);
    check("t5_ready_p8", bus_if.spi_ready_o, 1'b1);
    check("t5_spi_en_p8", bus_if.spi_en_o, 1'b0);
    step(1);
    check("t5_ready_p9", bus_if.spi_ready_o, 1'b0);

    // 6: reset mid-window, then regrant at first phase 15 after release
    goto_phase(14);
    bus_if.spi_valid_i = 1'b1;
    goto_phase(5);
    check("t6_spi_en_p5", bus_if.spi_en_o, 1'b1);
    reset_i = 1'b1;
    step(1);
    reset_i = 1'b0;
    check("t6_rst_spi_en", bus_if.spi_en_o, 1'b0);
    check("t6_rst_cpu_be", bus_if.cpu_be_o, 1'b1);
    check("t6_rst_strobe", bus_if.strobe_clk_o, 1'b0);
    check("t6_rst_setup", bus_if.setup_clk_o, 1'b0);
    check("t6_rst_cpu_clk", bus_if.cpu_clk_o, 1'b0);
    check("t6_rst_ready", bus_if.spi_ready_o, 1'b0);
    first_en = -1;
    for (int i = 1; i <= 40 && first_en < 0; i++) begin
      step(1);
      if (bus_if.spi_en_o) first_en = i;
    end
    check_n("t6_regrant_latency", first_en, 16);
    bus_if.spi_valid_i = 1'b0;
    step(12);

    // Random valid traffic with occasional resets, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 8) bus_if.spi_valid_i = !bus_if.spi_valid_i;
      reset_i = ($urandom_range(0, 299) == 0);
      step(1);
    end
    reset_i = 1'b0;
    bus_if.spi_valid_i = 1'b0;
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
